// File: rtl/reg_wr_req.sv
// Write-request initiator: queues producer writes in a small FIFO and issues them
// one at a time on the arbiter req/ack channel. Optional abort-on-timeout via REQ_TIMEOUT_EN.
module reg_wr_req #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [6:0]    wr_addr,
    input  logic [15:0]   wr_data,
    output logic          req,
    input  logic          ack,
    output logic [6:0]    addr,
    output logic [15:0]   dout,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          timeout_err
);

    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH != (1 << AW)) begin : g_bad_depth
        $error("reg_wr_req: DEPTH must be a power of two >= 2 and equal 2**AW");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("reg_wr_req: TIMEOUT must be in 1..255");
    end

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } entry_t;

    typedef enum logic {IDLE, REQ} state_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   level_q, level_d;
    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [6:0]    addr_q, addr_d;
    logic [15:0]   dout_q, dout_d;
    logic          push, pop;

`ifdef REQ_TIMEOUT_EN
    logic [7:0]    cnt_q, cnt_d;
    logic          terr_q, terr_d;
`endif

    assign push = wr_valid && wr_ready;

    // Next-state: issue the head entry from IDLE, hold it stable until ack (or abort)
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        pop     = 1'b0;
`ifdef REQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    addr_d  = mem[rd_ptr].addr;
                    dout_d  = mem[rd_ptr].data;
                    req_d   = 1'b1;
                    state_d = REQ;
`ifdef REQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
`ifdef REQ_TIMEOUT_EN
                // ack has priority over the limit on the same edge
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            level_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            level_q <= level_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage needs no reset: occupancy is tracked by level/pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
    end

`ifdef REQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign wr_ready = (level_q != FULL_LEVEL);
    assign busy     = (level_q != '0) || req_q;
    assign req      = req_q;
    assign addr     = addr_q;
    assign dout     = dout_q;
    assign level    = level_q;

endmodule

// File: doc/reg_wr_req.md
# reg_wr_req

Client-side initiator for the register-table write arbiter. It buffers register writes from a port-side producer in a small FIFO and presents them one at a time on the arbiter's req/ack write interface, holding address and data stable until the grant completes. One instance sits beside each requester (SPI, port0..port3), between that requester's logic and its arbiter request channel.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- AW, 2, log2(DEPTH)
- TIMEOUT, 255, cycles in REQ without ack before abort (only with REQ_TIMEOUT_EN); 1..255
- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  producer offers a write this cycle
- wr_ready  out  1  FIFO not full; push happens when wr_valid && wr_ready at clk edge
- wr_addr  in  7  register address to write
- wr_data  in  16  register data to write
- req  out  1  write request to arbiter (registered)
- ack  in  1  one-cycle grant pulse from arbiter
- addr  out  7  address presented with req (registered)
- dout  out  16  data presented with req (registered)
- level  out  AW+1  FIFO occupancy 0..DEPTH
- busy  out  1  level != 0 or req high
- timeout_err  out  1  one-cycle pulse on aborted request (tied 0 without REQ_TIMEOUT_EN)

## Operation
- FIFO: circular buffer, rd/wr pointers AW bits, wrap modulo DEPTH; level counts 0..DEPTH. wr_ready = (level != DEPTH), combinational from registered level.
- FSM states IDLE, REQ.
- IDLE: if level != 0 at edge → load head entry into addr/dout, pop it, req<=1, go REQ. Otherwise hold.
- REQ: req stays high, addr/dout frozen. If ack sampled 1 at edge → req<=0, go IDLE.
- ack in IDLE ignored.
- Push and pop in same edge: level unchanged, both pointers advance. Push while full impossible (wr_ready low); wr_valid ignored.
- addr/dout retain last issued values after req drops until next load.
- Reset: FIFO emptied (pointers, level = 0), state IDLE, timeout counter 0.

## Timing
- Reset values: req=0, addr=0, dout=0, level=0, wr_ready=1, busy=0, timeout_err=0.
- Push at edge E0 into empty FIFO while IDLE: level=1 after E0; req, addr, dout valid after E1; level=0 after E1.
- Arbiter acks no earlier than the cycle after req rises; ack lasts one cycle, and the table latches addr/dout at the edge ending that ack cycle, so addr/dout must be stable through it.
- Edge sampling ack=1: req falls. req is low for exactly one cycle before a queued next entry is issued (arbiter is in its release cycle then, so no double grant).
- Back-to-back throughput: one write per 3 cycles with immediate ack.
- Reset asserted mid-REQ: req drops asynchronously; in-flight and queued entries lost; late ack after reset ignored.

## Configuration
- REQ_TIMEOUT_EN defined: an 8-bit counter clears on entering REQ and increments each REQ cycle without ack. On reaching TIMEOUT: req<=0, timeout_err=1 for one cycle, entry discarded, go IDLE. If ack and the limit coincide on one edge, ack wins: normal completion, no timeout_err.
- Undefined: REQ waits indefinitely for ack; no counter; timeout_err constant 0.

## Test plan
- Single write: push addr 0x05, data 0xA5A5; ack 2 cycles after req rises → req high 3 cycles; addr=0x05, dout=0xA5A5 during ack; level back to 0; busy falls after req.
- Burst: push 3 entries on consecutive cycles (0x01/0x1111, 0x02/0x2222, 0x03/0x3333), ack one cycle after each req → issued in order, req low exactly 1 cycle between grants.
- Full: hold ack low, push 5 entries → wr_ready low after level=4 (the first entry popped, so 4 queued plus 1 in REQ); 6th push held off until next ack pop.
- Spurious ack: ack pulse while IDLE and empty → no state change, req stays 0.
- Reset mid-REQ with 2 queued: assert rst → req=0, level=0 immediately; after release, ack pulse ignored.
- With REQ_TIMEOUT_EN, TIMEOUT=8, ack never sent → req drops after 8 REQ cycles, timeout_err pulses once, next entry issued one cycle later.
